// File: rtl/irq_stim_pkg.sv
// Shared constants for the interrupt stimulus generator: channel mode
// encodings and the width/ceiling of the per-channel overrun counters.
package irq_stim_pkg;

  localparam logic MODE_PULSE = 1'b0;
  localparam logic MODE_LEVEL = 1'b1;

  localparam int unsigned OVR_W = 8;
  localparam logic [OVR_W-1:0] OVR_MAX = 8'hFF;

endpackage

// File: rtl/irq_stim_chan.sv
// One periodic interrupt channel: a down-counter that raises an event every
// PERIOD enabled cycles, a pulse/level output stage and a saturating
// overrun counter for level events that land on an unacknowledged line.
module irq_stim_chan
  import irq_stim_pkg::*;
#(
  parameter int unsigned      CNT_W  = 16,
  parameter logic [CNT_W-1:0] PERIOD = 16'h2000,
  parameter logic             MODE   = MODE_PULSE
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             ack,
  output logic             irq_o,
  output logic             fire_o,
  output logic [OVR_W-1:0] overrun_o
);

  localparam logic [CNT_W-1:0] RELOAD = PERIOD - CNT_W'(1'b1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_irq;
  logic             w_irq_nxt;
  logic             r_fire;
  logic [OVR_W-1:0] r_ovr;
  logic [OVR_W-1:0] w_ovr_nxt;
  logic             w_active;
  logic             w_event;

  // A zero period parks the channel permanently, regardless of enable.
  assign w_active = enable && (PERIOD != {CNT_W{1'b0}});
  assign w_event  = w_active && (r_cnt == {CNT_W{1'b0}});

  // Next counter value: reload on event, count down while active, else hold.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_active) begin
      if (r_cnt == {CNT_W{1'b0}}) begin
        w_cnt_nxt = RELOAD;
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1'b1);
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Output stage: pulse follows the event; level latches until acked, and an
  // event always beats a same-cycle ack. Overrun counts events on a set bit.
  always_comb begin
    w_irq_nxt = 1'b0;
    w_ovr_nxt = r_ovr;
    case (MODE)
      MODE_LEVEL: begin
        if (w_event) begin
          w_irq_nxt = 1'b1;
          if (r_irq && (r_ovr != OVR_MAX)) begin
            w_ovr_nxt = r_ovr + OVR_W'(1'b1);
          end else begin
            w_ovr_nxt = r_ovr;
          end
        end else if (ack) begin
          w_irq_nxt = 1'b0;
        end else begin
          w_irq_nxt = r_irq;
        end
      end
      default: begin
        w_irq_nxt = w_event;
      end
    endcase
  end

  // State registers; reset restarts the count from PERIOD-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= RELOAD;
      r_irq  <= 1'b0;
      r_fire <= 1'b0;
      r_ovr  <= {OVR_W{1'b0}};
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_irq  <= w_irq_nxt;
      r_fire <= w_event;
      r_ovr  <= w_ovr_nxt;
    end
  end

  assign irq_o     = r_irq;
  assign fire_o    = r_fire;
  assign overrun_o = r_ovr;

endmodule

// File: rtl/irq_stim_gen.sv
// Interrupt stimulus generator: NUM_CH independent periodic channels, each
// mapped onto its own line of the IRQ vector and acknowledged via eoi.
module irq_stim_gen
  import irq_stim_pkg::*;
#(
  parameter int unsigned              IRQ_W     = 32,
  parameter int unsigned              NUM_CH    = 2,
  parameter int unsigned              CNT_W     = 16,
  parameter logic [NUM_CH*5-1:0]      CH_LINE   = {5'd5, 5'd4},
  parameter logic [NUM_CH*CNT_W-1:0]  CH_PERIOD = {16'hFFFF, 16'h2000},
  parameter logic [NUM_CH-1:0]        CH_MODE   = 2'b00
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic [IRQ_W-1:0]        eoi,
  output logic [IRQ_W-1:0]        irq,
  output logic [NUM_CH-1:0]       fire,
  output logic [NUM_CH*OVR_W-1:0] overrun
);

  logic [NUM_CH-1:0] w_ch_irq;
  logic [NUM_CH-1:0] w_ack;
  logic [IRQ_W-1:0]  w_irq;

  if ((NUM_CH < 1) || (NUM_CH > 8)) begin : g_bad_num
    $error("irq_stim_gen: NUM_CH must be in 1..8");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [4:0] LINE = CH_LINE[5*i +: 5];

    if ({27'd0, LINE} >= IRQ_W) begin : g_bad_line
      $error("irq_stim_gen: CH_LINE entry is not below IRQ_W");
    end

    for (genvar j = i + 1; j < NUM_CH; j++) begin : g_dup
      if (CH_LINE[5*j +: 5] == LINE) begin : g_clash
        $error("irq_stim_gen: two channels share one IRQ line");
      end
    end

    assign w_ack[i] = eoi[LINE];

    irq_stim_chan #(
      .CNT_W  (CNT_W),
      .PERIOD (CH_PERIOD[CNT_W*i +: CNT_W]),
      .MODE   (CH_MODE[i])
    ) u_chan (
      .clk       (clk),
      .resetn    (resetn),
      .enable    (enable),
      .ack       (w_ack[i]),
      .irq_o     (w_ch_irq[i]),
      .fire_o    (fire[i]),
      .overrun_o (overrun[OVR_W*i +: OVR_W])
    );
  end

  // Scatter the registered channel outputs onto their lines; others stay 0.
  always_comb begin
    w_irq = {IRQ_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      w_irq[CH_LINE[5*k +: 5]] = w_ch_irq[k];
    end
  end

  assign irq = w_irq;

endmodule

// File: tb/tb_irq_stim_gen.sv
// Scoreboard bench for irq_stim_gen. Four instances cover: two pulse
// channels (P=3 on line 4, P=8 on line 5), freeze with P=4 pulse, level+ack
// with P=5, and overrun/collision/async reset/saturation with P=2 level.
module tb_irq_stim_gen;

  typedef struct {
    int          inst;
    logic [31:0] irq;
    logic [1:0]  fire;
    logic [15:0] ovr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0, en_c = 1'b0, en_d = 1'b0;
  logic [31:0] eoi_zero = 32'd0;
  logic [31:0] eoi_c = 32'd0, eoi_d = 32'd0;

  logic [31:0] irq_a, irq_b, irq_c, irq_d;
  logic [1:0]  fire_a;
  logic        fire_b, fire_c, fire_d;
  logic [15:0] ovr_a;
  logic [7:0]  ovr_b, ovr_c, ovr_d;

  irq_stim_gen #(.IRQ_W(32), .NUM_CH(2), .CNT_W(16), .CH_LINE({5'd5, 5'd4}),
                 .CH_PERIOD({16'd8, 16'd3}), .CH_MODE(2'b00)) u_a (
    .clk(clk), .resetn(rst_a), .enable(en_a), .eoi(eoi_zero),
    .irq(irq_a), .fire(fire_a), .overrun(ovr_a));

  irq_stim_gen #(.IRQ_W(32), .NUM_CH(1), .CNT_W(16), .CH_LINE(5'd5),
                 .CH_PERIOD(16'd4), .CH_MODE(1'b0)) u_b (
    .clk(clk), .resetn(rst_b), .enable(en_b), .eoi(eoi_zero),
    .irq(irq_b), .fire(fire_b), .overrun(ovr_b));

  irq_stim_gen #(.IRQ_W(32), .NUM_CH(1), .CNT_W(16), .CH_LINE(5'd4),
                 .CH_PERIOD(16'd5), .CH_MODE(1'b1)) u_c (
    .clk(clk), .resetn(rst_c), .enable(en_c), .eoi(eoi_c),
    .irq(irq_c), .fire(fire_c), .overrun(ovr_c));

  irq_stim_gen #(.IRQ_W(32), .NUM_CH(1), .CNT_W(16), .CH_LINE(5'd4),
                 .CH_PERIOD(16'd2), .CH_MODE(1'b1)) u_d (
    .clk(clk), .resetn(rst_d), .enable(en_d), .eoi(eoi_d),
    .irq(irq_d), .fire(fire_d), .overrun(ovr_d));

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0t got=%h expected=%h", nm, inst, $time, got, want);
    end
  endtask

  task automatic push(input int inst, input logic [31:0] ei, input logic [1:0] ef, input logic [15:0] eo);
    exp_t t;
    t.inst = inst;
    t.irq  = ei;
    t.fire = ef;
    t.ovr  = eo;
    q.push_back(t);
  endtask

  task automatic pick(input int inst, output logic [31:0] gi, output logic [1:0] gf, output logic [15:0] go);
    case (inst)
      0: begin gi = irq_a; gf = fire_a;        go = ovr_a;          end
      1: begin gi = irq_b; gf = {1'b0, fire_b}; go = {8'd0, ovr_b}; end
      2: begin gi = irq_c; gf = {1'b0, fire_c}; go = {8'd0, ovr_c}; end
      default: begin gi = irq_d; gf = {1'b0, fire_d}; go = {8'd0, ovr_d}; end
    endcase
  endtask

  // Monitor: each entry queued before an edge is compared just after it.
  exp_t        m_e;
  logic [31:0] m_irq;
  logic [1:0]  m_fire;
  logic [15:0] m_ovr;
  always @(posedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      #1;
      pick(m_e.inst, m_irq, m_fire, m_ovr);
      chk("irq", m_e.inst, m_irq, m_e.irq);
      chk("fire", m_e.inst, {30'd0, m_fire}, {30'd0, m_e.fire});
      chk("overrun", m_e.inst, {16'd0, m_ovr}, {16'd0, m_e.ovr});
    end
  end

  logic [31:0] ei;
  int          m;
  logic [7:0]  tbl_irq, tbl_fire, tbl_ovr;

  initial begin
    // Reset defaults, then pulses on line 4 every 3 edges and line 5 every 8.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      push(0, 32'd0, 2'b00, 16'd0);
    end
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n == 1) begin rst_a = 1'b1; en_a = 1'b1; end
      ei = 32'd0;
      if (n % 3 == 0) ei[4] = 1'b1;
      if (n % 8 == 0) ei[5] = 1'b1;
      push(0, ei, {ei[5], ei[4]}, 16'd0);
    end

    // Freeze: 2 enabled edges, 10 frozen, then pulses every 4 enabled edges.
    m = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 1) rst_b = 1'b1;
      en_b = (c <= 2) || (c > 12);
      if (en_b) m++;
      ei = 32'd0;
      if (en_b && (m % 4 == 0)) ei[5] = 1'b1;
      push(1, ei, {1'b0, ei[5]}, 16'd0);
    end

    // Level with ack two cycles after set.
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n == 1) begin rst_c = 1'b1; en_c = 1'b1; end
      eoi_c = 32'd0;
      if (n == 7 || n == 12) eoi_c[4] = 1'b1;
      ei = 32'd0;
      if (n == 5 || n == 6 || n == 10 || n == 11 || n == 15) ei[4] = 1'b1;
      push(2, ei, {1'b0, (n % 5 == 0)}, 16'd0);
    end

    // Level P=2 never acked: overrun climbs to 7 by edge 16.
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 1) begin rst_d = 1'b1; en_d = 1'b1; end
      ei = 32'd0;
      if (n >= 2) ei[4] = 1'b1;
      push(3, ei, {1'b0, (n % 2 == 0)}, (n >= 2) ? 16'(n / 2 - 1) : 16'd0);
    end
    // Async reset between edges clears outputs with no clock edge.
    @(posedge clk);
    #3;
    rst_d = 1'b0;
    #1;
    chk("async_irq", 3, irq_d, 32'd0);
    chk("async_fire", 3, {31'd0, fire_d}, 32'd0);
    chk("async_overrun", 3, {24'd0, ovr_d}, 32'd0);
    @(negedge clk);
    push(3, 32'd0, 2'b00, 16'd0);

    // Restart, ack at edges 3,6,7; edge 6 is an event colliding with ack.
    tbl_irq  = 8'b1011_1010;
    tbl_fire = 8'b1010_1010;
    tbl_ovr  = 8'b1110_0000;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) rst_d = 1'b1;
      eoi_d = 32'd0;
      if (n == 3 || n == 6 || n == 7) eoi_d[4] = 1'b1;
      ei = 32'd0;
      ei[4] = tbl_irq[n-1];
      push(3, ei, {1'b0, tbl_fire[n-1]}, {15'd0, tbl_ovr[n-1]});
    end

    // Saturation: 265 unacked events, overrun stops at 255.
    @(negedge clk);
    eoi_d = 32'd0;
    rst_d = 1'b0;
    push(3, 32'd0, 2'b00, 16'd0);
    for (int n = 1; n <= 530; n++) begin
      @(negedge clk);
      if (n == 1) rst_d = 1'b1;
      ei = 32'd0;
      if (n >= 2) ei[4] = 1'b1;
      push(3, ei, {1'b0, (n % 2 == 0)},
           (n < 2) ? 16'd0 : ((n / 2 - 1) > 255 ? 16'd255 : 16'(n / 2 - 1)));
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_stim_gen.md
# irq_stim_gen

Parametrised interrupt stimulus generator for the SoC testbenches. It drives the CPU `irq` vector from NUM_CH independent periodic channels. Each channel has its own period, target IRQ line and pulse/level mode. Level channels are acknowledged through the CPU's `eoi` vector, and overruns are counted. It is instantiated in testbenches next to `top` to exercise FreeRTOS tick and secondary interrupts.

## Interface
- `IRQ_W`, 32: width of `irq`/`eoi` vectors.
- `NUM_CH`, 2: number of channels, 1..8.
- `CNT_W`, 16: width of per-channel period counters.
- `CH_LINE`, {5'd5, 5'd4}: packed NUM_CH×5 bits; channel i drives `irq[CH_LINE[5i+:5]]`. Lines must be distinct and < IRQ_W; violation reported by `$error` at elaboration/time 0.
- `CH_PERIOD`, {16'd65536-1, 16'd8192}: packed NUM_CH×CNT_W; enabled-cycle period P; P=0 disables channel.
- `CH_MODE`, 2'b00: packed NUM_CH bits; 0 = pulse, 1 = level.
- `clk`  input  1  clock, all state on rising edge.
- `resetn`  input  1  asynchronous, active-low reset.
- `enable`  input  1  global run; counters advance only while high.
- `eoi`  input  IRQ_W  end-of-interrupt from CPU, sampled each cycle.
- `irq`  output  IRQ_W  registered interrupt vector; unmapped bits constant 0.
- `fire`  output  NUM_CH  registered one-cycle strobe per channel event.
- `overrun`  output  NUM_CH×8  per-channel saturating overrun counts.

## Operation
- Reset (async, resetn=0): per-channel down-counter ← P−1, `irq`=0, `fire`=0, `overrun`=0. Applies immediately mid-operation; counters restart from P−1 on release.
- Per channel, each edge with enable=1 and P≠0: counter==0 → event, reload P−1; else decrement. enable=0 freezes counter; no events.
- Event → `fire[i]`=1 for exactly the next cycle.
- Pulse mode: `irq[line]`=1 for exactly the cycle after the event; `eoi` ignored.
- Level mode: event sets `irq[line]`; `eoi[line]`=1 on an edge with no event clears it at that edge.
- Simultaneous event and `eoi[line]`: event wins, bit stays 1, overrun +1.
- Event while level bit already set (no eoi): bit stays 1, overrun +1.
- Overrun counter 8 bits, saturates at 255, never wraps; only reset clears it. Pulse channels never overrun.
- P=1: event every enabled cycle; pulse mode gives `irq` continuously high while enable=1.
- enable dropping does not cancel a pending pulse or a set level bit.

## Timing
- Latency: event detected at edge k → `irq`/`fire` high after edge k (visible cycle k+1); pulse low again after edge k+1.
- First event on the P-th enabled edge after reset release; subsequent events every P enabled edges. P=8192 matches the legacy `&count[12:0]` tick rate.
- Level clear: `eoi` high at edge k → `irq` low after edge k.
- No combinational path from `eoi`/`enable` to any output.

## Structure
- Package `irq_stim_pkg`: `MODE_PULSE`=1'b0, `MODE_LEVEL`=1'b1, `OVR_W`=8, `OVR_MAX`=8'hFF.
- Sub-module `irq_stim_chan`: one channel (down-counter, mode logic, overrun counter), parameters PERIOD, MODE, CNT_W; ports clk, resetn, enable, ack, irq_o, fire_o, overrun_o. Generated NUM_CH times; top maps `ack`=`eoi[line]`, scatters `irq_o` to `irq[line]`.
- Line-distinctness check lives in the top generate block.

## Test plan
- Reset defaults: P={8,3}, pulse; hold resetn=0 → `irq`=0, `fire`=0, `overrun`=0; release, enable=1 → `irq[4]` high cycles 3,6,9…, `irq[5]` high cycles 8,16,… (1-cycle pulses).
- Freeze: P=4 pulse, drop enable for 10 cycles after 2 enabled edges → next pulse exactly 2 enabled edges after re-enable.
- Level + ack: P=5 level, line 4; `eoi[4]` pulsed 2 cycles after set → `irq[4]` cleared next edge, set again 5 enabled edges after previous event; `overrun`=0.
- Overrun: P=2 level, never ack → `irq[4]` stays 1, overrun 1,2,… saturates at 255 after 256 events total, no wrap.
- Collision: schedule `eoi[4]` on the event edge → `irq[4]` remains 1, overrun increments by 1.
- Async reset mid-run: drop resetn between edges while `irq[4]`=1 and overrun=7 → outputs 0 immediately without a clock edge; after release first event at P-th edge.
